// File: rtl/aclk_ctrl_fsm_if.sv
// ============================================================================
// aclk_ctrl_fsm_if : keypad/button inputs and load/display controls of the
//                    alarm-clock control FSM.  Rev 1.0
// ============================================================================
`default_nettype none

interface aclk_ctrl_fsm_if;
  logic       one_second;
  logic [3:0] key;
  logic       key_valid;
  logic       alarm_button;
  logic       time_button;
  logic       shift;
  logic       show_new_time;
  logic       show_a;
  logic       load_new_a;
  logic       load_new_c;
  logic       reset_count;

  modport master (
    output one_second, key, key_valid, alarm_button, time_button,
    input  shift, show_new_time, show_a, load_new_a, load_new_c, reset_count
  );

  modport slave (
    input  one_second, key, key_valid, alarm_button, time_button,
    output shift, show_new_time, show_a, load_new_a, load_new_c, reset_count
  );
endinterface

`default_nettype wire

// File: rtl/aclk_ctrl_fsm.sv
// ============================================================================
// aclk_ctrl_fsm : Moore FSM sequencing keypad entry and alarm/time loads.
//                 Rev 1.0
// ============================================================================
`default_nettype none

module aclk_ctrl_fsm #(
  parameter int NUM_DIGITS = 4,
  parameter int TIMEOUT_S  = 10
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  aclk_ctrl_fsm_if.slave   bus
);

  localparam int DCNT_W = $clog2(NUM_DIGITS + 1);
  localparam int TMO_W  = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;

  localparam logic [DCNT_W-1:0] C_DCNT_FULL = DCNT_W'(NUM_DIGITS);
  localparam logic [TMO_W-1:0]  C_TMO_LAST  = TMO_W'(TIMEOUT_S - 1);

  typedef enum logic [2:0] {
    SHOW_TIME  = 3'd0,
    KEY_STORED = 3'd1,
    KEY_ENTRY  = 3'd2,
    SHOW_ALARM = 3'd3,
    SET_ALARM  = 3'd4,
    SET_TIME   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [DCNT_W-1:0] digit_cnt_q, digit_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              w_digit;
  logic              w_full;

  // Codes 10-15 are never treated as digits, in any state.
  assign w_digit = bus.key_valid && (bus.key <= 4'd9);
  assign w_full  = (digit_cnt_q == C_DCNT_FULL);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= SHOW_TIME;
      digit_cnt_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      digit_cnt_q <= digit_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    digit_cnt_d = digit_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    case (state_q)
      SHOW_TIME: begin
        if (w_digit) begin
          state_d     = KEY_STORED;
          digit_cnt_d = DCNT_W'(1);
        end else if (bus.alarm_button) begin
          state_d = SHOW_ALARM;
        end
      end
      KEY_STORED: begin
        state_d   = KEY_ENTRY;
        tmo_cnt_d = '0;
      end
      KEY_ENTRY: begin
        // A digit outranks any button; buttons are re-evaluated on the next visit.
        if (w_digit) begin
          state_d = KEY_STORED;
          if (!w_full) digit_cnt_d = digit_cnt_q + DCNT_W'(1);
        end else if (bus.alarm_button && w_full) begin
          state_d = SET_ALARM;
        end else if (bus.time_button && w_full) begin
          state_d = SET_TIME;
        end else if (bus.one_second && (tmo_cnt_q == C_TMO_LAST)) begin
          state_d     = SHOW_TIME;
          digit_cnt_d = '0;
        end else if (bus.one_second) begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      SHOW_ALARM: begin
        if (!bus.alarm_button) state_d = SHOW_TIME;
      end
      SET_ALARM, SET_TIME: begin
        state_d     = SHOW_TIME;
        digit_cnt_d = '0;
      end
      default: state_d = SHOW_TIME;
    endcase
  end

  always_comb begin
    bus.shift         = 1'b0;
    bus.show_new_time = 1'b0;
    bus.show_a        = 1'b0;
    bus.load_new_a    = 1'b0;
    bus.load_new_c    = 1'b0;
    bus.reset_count   = 1'b0;
    case (state_q)
      KEY_STORED: begin
        bus.shift         = 1'b1;
        bus.show_new_time = 1'b1;
      end
      KEY_ENTRY:  bus.show_new_time = 1'b1;
      SHOW_ALARM: bus.show_a        = 1'b1;
      SET_ALARM:  bus.load_new_a    = 1'b1;
      SET_TIME: begin
        bus.load_new_c  = 1'b1;
        bus.reset_count = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_aclk_ctrl_fsm.sv
// ============================================================================
// tb_aclk_ctrl_fsm : directed self-checking bench for aclk_ctrl_fsm.
//                    Rev 1.0
// ============================================================================
`default_nettype none

module tb_aclk_ctrl_fsm;

  // Output vector order: {shift, show_new_time, show_a, load_new_a, load_new_c, reset_count}
  localparam logic [5:0] C_IDLE   = 6'b000000;
  localparam logic [5:0] C_STORED = 6'b110000;
  localparam logic [5:0] C_ENTRY  = 6'b010000;
  localparam logic [5:0] C_ALARM  = 6'b001000;
  localparam logic [5:0] C_LDA    = 6'b000100;
  localparam logic [5:0] C_LDC    = 6'b000011;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  aclk_ctrl_fsm_if bus ();

  aclk_ctrl_fsm #(.NUM_DIGITS(4), .TIMEOUT_S(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {bus.shift, bus.show_new_time, bus.show_a,
           bus.load_new_a, bus.load_new_c, bus.reset_count};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Strobe one key for one cycle, check the stored state, then `gap` entry cycles.
  task automatic press(input logic [3:0] k, input int gap, input string tag);
    bus.key       = k;
    bus.key_valid = 1'b1;
    tick();
    chk({tag, "_stored"}, C_STORED);
    bus.key_valid = 1'b0;
    bus.key       = 4'd0;
    for (int i = 0; i < gap; i++) begin
      tick();
      chk({tag, "_entry"}, C_ENTRY);
    end
  endtask

  task automatic sec(input logic [5:0] exp, input string tag);
    bus.one_second = 1'b1;
    tick();
    bus.one_second = 1'b0;
    chk(tag, exp);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n          = 1'b0;
    bus.one_second   = 1'b0;
    bus.key          = 4'd0;
    bus.key_valid    = 1'b0;
    bus.alarm_button = 1'b0;
    bus.time_button  = 1'b0;

    // T1: reset with random inputs
    for (int i = 0; i < 2; i++) begin
      bus.one_second   = 1'($urandom);
      bus.key          = 4'($urandom);
      bus.key_valid    = 1'($urandom);
      bus.alarm_button = 1'($urandom);
      bus.time_button  = 1'($urandom);
      tick();
      chk("t1_reset", C_IDLE);
    end
    reset_n          = 1'b1;
    bus.one_second   = 1'b0;
    bus.key          = 4'd0;
    bus.key_valid    = 1'b0;
    bus.alarm_button = 1'b0;
    bus.time_button  = 1'b0;
    tick();
    chk("t1_release", C_IDLE);

    // Non-digit codes and a lone time_button leave SHOW_TIME alone
    bus.key = 4'd12; bus.key_valid = 1'b1;
    tick();
    chk("nondigit_idle", C_IDLE);
    bus.key_valid = 1'b0; bus.time_button = 1'b1;
    tick();
    chk("time_btn_idle", C_IDLE);
    bus.time_button = 1'b0;

    // T2: time set
    press(4'd1, 4, "t2_d1");
    press(4'd2, 4, "t2_d2");
    bus.key = 4'd11; bus.key_valid = 1'b1;
    tick();
    chk("t2_nondigit_entry", C_ENTRY);
    bus.key_valid = 1'b0;
    press(4'd3, 4, "t2_d3");
    press(4'd4, 4, "t2_d4");
    bus.time_button = 1'b1;
    tick();
    chk("t2_set_time", C_LDC);
    bus.time_button = 1'b0;
    tick();
    chk("t2_back_idle", C_IDLE);

    // T3: short entry, then completing digit with button held
    press(4'd7, 1, "t3_d1");
    press(4'd8, 1, "t3_d2");
    press(4'd9, 1, "t3_d3");
    bus.alarm_button = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t3_short_hold", C_ENTRY);
    end
    press(4'd0, 1, "t3_d4");
    tick();
    chk("t3_set_alarm", C_LDA);
    tick();
    chk("t3_return_idle", C_IDLE);
    tick();
    chk("t3_held_to_alarm", C_ALARM);
    bus.alarm_button = 1'b0;
    tick();
    chk("t3_alarm_release", C_IDLE);

    // T4: timeout, then a digit at tick 9 restarts the count
    press(4'd5, 1, "t4_d1");
    for (int i = 1; i <= 9; i++) sec(C_ENTRY, "t4_tick_wait");
    sec(C_IDLE, "t4_timeout");
    press(4'd6, 1, "t4_d2");
    for (int i = 1; i <= 9; i++) sec(C_ENTRY, "t4_tick_wait2");
    press(4'd7, 1, "t4_restart");
    for (int i = 1; i <= 9; i++) sec(C_ENTRY, "t4_tick_wait3");
    sec(C_IDLE, "t4_timeout2");

    // T5: alarm display, digit during display ignored
    bus.alarm_button = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.key       = 4'd3;
      bus.key_valid = (i == 4);
      tick();
      chk("t5_show_a", C_ALARM);
    end
    bus.key_valid    = 1'b0;
    bus.alarm_button = 1'b0;
    tick();
    chk("t5_release", C_IDLE);
    tick();
    chk("t5_idle", C_IDLE);

    // T6: reset in KEY_STORED, then a fresh entry counts from 1
    press(4'd1, 1, "t6_pre");
    press(4'd2, 0, "t6_pre2");
    reset_n = 1'b0;
    tick();
    chk("t6_reset_mid", C_IDLE);
    reset_n = 1'b1;
    tick();
    chk("t6_after_reset", C_IDLE);
    press(4'd1, 1, "t6_d1");
    press(4'd2, 1, "t6_d2");
    press(4'd3, 1, "t6_d3");
    bus.time_button = 1'b1;
    tick();
    chk("t6_three_no_load", C_ENTRY);
    bus.time_button = 1'b0;
    press(4'd4, 1, "t6_d4");
    press(4'd5, 1, "t6_d5_sat");
    bus.time_button = 1'b1;
    tick();
    chk("t6_set_time", C_LDC);
    bus.time_button = 1'b0;
    tick();
    chk("t6_idle", C_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
